// File: rtl/fib_pkg.sv
// fib_pkg: shared FSM state encoding, mux select codes and datapath width for the Fibonacci sequencer
package fib_pkg;
  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} fib_state_e;
  localparam logic SEL_INIT = 1'b0;
  localparam logic SEL_STEP = 1'b1;
  localparam int DATA_W = 32;
endpackage

// File: rtl/fib_seq_ctrl_if.sv
// fib_seq_ctrl_if: start/done handshake plus datapath control bundle for fib_seq_ctrl
//  start  request, n iteration count, abort cancel (only with FIB_SEQ_CTRL_ABORT_EN)
//  sel    mux select (0 init, 1 step), en flop enable, busy, done pulse
//  master = requester/datapath side, slave = controller side
interface fib_seq_ctrl_if #(parameter int N_W = 6);
  logic           start;
  logic [N_W-1:0] n;
  logic           sel;
  logic           en;
  logic           busy;
  logic           done;
`ifdef FIB_SEQ_CTRL_ABORT_EN
  logic           abort;
  modport master (output start, n, abort, input sel, en, busy, done);
  modport slave  (input start, n, abort, output sel, en, busy, done);
`else
  modport master (output start, n, input sel, en, busy, done);
  modport slave  (input start, n, output sel, en, busy, done);
`endif
endinterface

// File: rtl/fib_iter_cnt.sv
// fib_iter_cnt: iteration down counter for the Fibonacci sequencer
//  clk, rstn (async active-low), i_load loads i_d, i_dec decrements (saturates at 0),
//  o_is_zero / o_is_one flag the current count
module fib_iter_cnt #(parameter int N_W = 6) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           i_load,
  input  logic           i_dec,
  input  logic [N_W-1:0] i_d,
  output logic           o_is_zero,
  output logic           o_is_one
);
  logic [N_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_cnt <= '0;
    else if (i_load) r_cnt <= i_d;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_is_zero = r_cnt == '0;
  assign o_is_one  = r_cnt == N_W'(1);
endmodule

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: Moore FSM sequencing the a/b Fibonacci datapath until a = fib(n)
//  clk, rstn (async active-low), bus (fib_seq_ctrl_if.slave): start/n in, sel/en/busy/done out
//  FIB_SEQ_CTRL_ABORT_EN adds bus.abort: cancels a run in INIT/RUN, gating en in the same cycle
module fib_seq_ctrl import fib_pkg::*; #(parameter int N_W = 6) (
  input logic           clk,
  input logic           rstn,
  fib_seq_ctrl_if.slave bus
);
  fib_state_e r_state, w_nxt;
  logic r_sel, r_en, r_busy, r_done;
  logic w_zero, w_one, w_abort;
  fib_iter_cnt #(.N_W(N_W)) u_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (r_state == IDLE && bus.start),
    .i_dec     (r_state == RUN),
    .i_d       (bus.n),
    .o_is_zero (w_zero),
    .o_is_one  (w_one)
  );
  always_comb begin
`ifdef FIB_SEQ_CTRL_ABORT_EN
    w_abort = bus.abort && (r_state == INIT || r_state == RUN);
`else
    w_abort = 1'b0;
`endif
    w_nxt = IDLE;
    case (r_state)
      IDLE:    w_nxt = bus.start ? INIT : IDLE;
      INIT:    w_nxt = w_zero ? DONE : RUN;
      RUN:     w_nxt = w_one ? DONE : RUN;
      default: w_nxt = IDLE;
    endcase
    if (w_abort) w_nxt = IDLE;
  end
  // outputs are registered from the next state so they track r_state exactly
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state <= IDLE;
      r_sel   <= SEL_INIT;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_sel   <= w_nxt == RUN ? SEL_STEP : SEL_INIT;
      r_en    <= w_nxt == INIT || w_nxt == RUN;
      r_busy  <= w_nxt == INIT || w_nxt == RUN;
      r_done  <= w_nxt == DONE;
    end
  assign bus.sel  = r_sel;
  assign bus.en   = r_en & ~w_abort;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: directed checks of fib_seq_ctrl driving a mux2/flop Fibonacci datapath
module tb_fib_seq_ctrl;
  import fib_pkg::*;
  logic clk, rstn;
  logic [DATA_W-1:0] a, b;
  int cmp, bad;
  fib_seq_ctrl_if #(.N_W(6)) bus ();
  fib_seq_ctrl #(.N_W(6)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      a <= '0;
      b <= '0;
    end else if (bus.en) begin
      a <= bus.sel ? b : '0;
      b <= bus.sel ? a + b : 1;
    end
  task automatic do_run(input int nv, output int en_c, output int done_c, output int done_k,
                        output logic [31:0] a_d, output logic s0, output logic s1, output logic busy_end);
    @(negedge clk);
    bus.start = 1;
    bus.n = 6'(nv);
    en_c = 0; done_c = 0; done_k = -1; a_d = 'x; s0 = 0; s1 = 0;
    for (int k = 1; k <= nv + 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 0;
      if (bus.en) en_c++;
      if (k == 1) s0 = bus.sel;
      if (k == 2) s1 = bus.sel;
      if (bus.done) begin
        done_c++;
        done_k = k;
        a_d = a;
      end
    end
    busy_end = bus.busy;
  endtask
  task automatic test_reset;
    rstn = 0;
    bus.start = 0;
    bus.n = 0;
`ifdef FIB_SEQ_CTRL_ABORT_EN
    bus.abort = 0;
`endif
    repeat (2) @(negedge clk);
    cmp++; if (bus.sel !== 1'b0) begin bad++; $display("FAIL reset_sel got %b want 0", bus.sel); end
    cmp++; if (bus.en !== 1'b0) begin bad++; $display("FAIL reset_en got %b want 0", bus.en); end
    cmp++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    cmp++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    rstn = 1;
    @(negedge clk);
  endtask
  task automatic test_run(input string nm, input int nv, input logic [31:0] exp_a, input logic exp_s1);
    int en_c, done_c, done_k;
    logic [31:0] a_d;
    logic s0, s1, be;
    do_run(nv, en_c, done_c, done_k, a_d, s0, s1, be);
    cmp++; if (en_c != nv + 1) begin bad++; $display("FAIL %s_en_cycles got %0d want %0d", nm, en_c, nv + 1); end
    cmp++; if (done_c != 1) begin bad++; $display("FAIL %s_done_count got %0d want 1", nm, done_c); end
    cmp++; if (done_k != nv + 2) begin bad++; $display("FAIL %s_done_edge got %0d want %0d", nm, done_k, nv + 2); end
    cmp++; if (a_d !== exp_a) begin bad++; $display("FAIL %s_a got %0d want %0d", nm, a_d, exp_a); end
    cmp++; if (s0 !== SEL_INIT) begin bad++; $display("FAIL %s_sel_first got %b want 0", nm, s0); end
    cmp++; if (s1 !== exp_s1) begin bad++; $display("FAIL %s_sel_second got %b want %b", nm, s1, exp_s1); end
    cmp++; if (be !== 1'b0) begin bad++; $display("FAIL %s_busy_after got %b want 0", nm, be); end
  endtask
  task automatic test_back_to_back;
    int done_c, done_k;
    logic [31:0] a_d;
    @(negedge clk);
    bus.start = 1;
    bus.n = 6'd10;
    done_c = 0; done_k = -1; a_d = 'x;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.done) begin
        done_c++;
        done_k = k;
        a_d = a;
      end
      bus.start = (k == 3 || k == 12);
      bus.n = 6'd5;
    end
    cmp++; if (done_c != 1) begin bad++; $display("FAIL ignore_done_count got %0d want 1", done_c); end
    cmp++; if (done_k != 12) begin bad++; $display("FAIL ignore_done_edge got %0d want 12", done_k); end
    cmp++; if (a_d !== 32'd55) begin bad++; $display("FAIL ignore_a got %0d want 55", a_d); end
    cmp++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_idle_busy got %b want 0", bus.busy); end
    test_run("after_ignore", 2, 32'd1, SEL_STEP);
  endtask
  task automatic test_mid_reset;
    int done_c;
    @(negedge clk);
    bus.start = 1;
    bus.n = 6'd10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 0;
    end
    @(negedge clk);
    cmp++; if (bus.en !== 1'b1) begin bad++; $display("FAIL midrst_en_before got %b want 1", bus.en); end
    rstn = 0;
    #1;
    cmp++; if (bus.en !== 1'b0) begin bad++; $display("FAIL midrst_en got %b want 0", bus.en); end
    cmp++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    done_c = 0;
    @(negedge clk);
    rstn = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) done_c++;
    end
    cmp++; if (done_c != 0) begin bad++; $display("FAIL midrst_no_done got %0d want 0", done_c); end
    test_run("after_rst", 3, 32'd2, SEL_STEP);
  endtask
`ifdef FIB_SEQ_CTRL_ABORT_EN
  task automatic test_abort;
    int done_c;
    @(negedge clk);
    bus.start = 1;
    bus.n = 6'd10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 0;
    end
    cmp++; if (bus.en !== 1'b1) begin bad++; $display("FAIL abort_en_before got %b want 1", bus.en); end
    bus.abort = 1;
    #1;
    cmp++; if (bus.en !== 1'b0) begin bad++; $display("FAIL abort_en_gate got %b want 0", bus.en); end
    @(negedge clk);
    bus.abort = 0;
    cmp++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_idle_busy got %b want 0", bus.busy); end
    done_c = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done || bus.en) done_c++;
    end
    cmp++; if (done_c != 0) begin bad++; $display("FAIL abort_quiet got %0d active cycles want 0", done_c); end
    test_run("after_abort", 5, 32'd5, SEL_STEP);
  endtask
`endif
  initial begin
    cmp = 0;
    bad = 0;
    test_reset;
    test_run("n0", 0, 32'd0, SEL_INIT);
    test_run("n1", 1, 32'd1, SEL_STEP);
    test_run("n10", 10, 32'd55, SEL_STEP);
    test_run("n63", 63, 32'd3350226146, SEL_STEP);
    test_back_to_back;
    test_mid_reset;
`ifdef FIB_SEQ_CTRL_ABORT_EN
    test_abort;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
